mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified word memory between the core's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported word memory between the fetch and the
//               load/store ports. Data has priority; fetch is forced after
//               STARVE_MAX consecutive data wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int c_WAIT_W   = $clog2(MEM_LAT + 1);
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [c_WAIT_W-1:0]   c_WAIT_LOAD = c_WAIT_W'(MEM_LAT);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MX = c_STARVE_W'(STARVE_MAX);
    localparam logic [c_STARVE_W-1:0] c_STARVE_1  = c_STARVE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_owner_d;
    logic                    r_we;
    logic [ADDR_W-3:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [c_WAIT_W-1:0]     r_wait_cnt;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic [DATA_W-1:0]       r_if_rdata;
    logic [DATA_W-1:0]       r_d_rdata;

    logic                    w_any_req;
    logic                    w_fetch_win;
    logic [DATA_W-1:0]       w_resp_data;
    logic                    w_unused;

    assign w_unused    = ^{if_addr[1:0], d_addr[1:0]};
    assign w_any_req   = if_req | d_req;
    // Fetch only beats a pending data request once it has been starved long enough
    assign w_fetch_win = if_req & (~d_req | (r_starve_cnt == c_STARVE_MX));
    assign w_resp_data = r_we ? '0 : mem_rdata;

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                // rst gates the grants so outputs are quiet during reset
                if_gnt = rst & w_fetch_win;
                d_gnt  = rst & d_req & ~w_fetch_win;
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_ONE) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if_rvalid   = ~r_owner_d;
                d_rvalid    = r_owner_d;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_d <= ~w_fetch_win;
                        r_we      <= ~w_fetch_win & d_we;
                        r_addr    <= w_fetch_win ? if_addr[ADDR_W-1:2] : d_addr[ADDR_W-1:2];
                        r_wdata   <= w_fetch_win ? '0 : d_wdata;
                    end
                    if (!if_req || w_fetch_win) begin
                        r_starve_cnt <= '0;
                    end else if (r_starve_cnt != c_STARVE_MX) begin
                        r_starve_cnt <= r_starve_cnt + c_STARVE_1;
                    end
                end
                S_ACCESS: begin
                    r_wait_cnt <= c_WAIT_LOAD;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - c_WAIT_ONE;
                    if (r_wait_cnt == c_WAIT_ONE) begin
                        if (r_owner_d) begin
                            r_d_rdata <= w_resp_data;
                        end else begin
                            r_if_rdata <= w_resp_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        t_if_gnt, t_if_rvalid, t_d_req, t_d_gnt, t_d_rvalid;
    logic        t_mem_en, t_mem_we, t_busy;
    logic [7:0]  t_d_addr;
    logic [31:0] t_if_rdata, t_d_rdata, t_mem_wdata;
    logic [5:0]  t_mem_addr;
    logic [31:0] t_q [3];

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(8'h00), .if_gnt(t_if_gnt),
        .if_rvalid(t_if_rvalid), .if_rdata(t_if_rdata),
        .d_req(t_d_req), .d_we(1'b0), .d_addr(t_d_addr), .d_wdata(32'h0),
        .d_gnt(t_d_gnt), .d_rvalid(t_d_rvalid), .d_rdata(t_d_rdata),
        .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_rdata(t_q[2]), .busy(t_busy)
    );

    function automatic logic [31:0] dflt(input logic [5:0] a);
        case (a)
            6'd0:    dflt = 32'h1234_5678;
            6'd1:    dflt = 32'hAAAA_5555;
            6'd2:    dflt = 32'h0050_0093;
            6'd3:    dflt = 32'h1111_2222;
            default: dflt = 32'h5A00_0000 | {26'd0, a};
        endcase
    endfunction

    // Memory for the MEM_LAT=1 instance: synchronous RAM, output held between reads
    logic [31:0] mem1 [64];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem1[i] <= dflt(6'(i));
            init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            mem_rdata <= mem1[mem_addr];
        end
    end

    // Read-only memory for the MEM_LAT=3 instance, delayed through a 3-stage pipe
    always @(posedge clk) begin
        if (t_mem_en) t_q[0] <= dflt(t_mem_addr);
        t_q[1] <= t_q[0];
        t_q[2] <= t_q[1];
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        int en_cnt;
        int rv_at;
        logic [1:0] exp_g;

        rst = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        t_d_req = 0; t_d_addr = 0;
        repeat (3) @(posedge clk);
        #2;
        // Reset state, with requests present
        if_req = 1; d_req = 1; #1;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_d_gnt", 32'(d_gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_if_rdata", if_rdata, 0);
        if_req = 0; d_req = 0;
        cyc();
        rst = 1'b1;

        // 1: fetch read of word 2
        cyc();
        if_req = 1; if_addr = 8'h08; #1;
        chk("t1_if_gnt", 32'(if_gnt), 1);
        chk("t1_d_gnt", 32'(d_gnt), 0);
        cyc(); if_req = 0; #1;
        chk("t1_mem_en", 32'(mem_en), 1);
        chk("t1_mem_addr", 32'(mem_addr), 2);
        chk("t1_mem_we", 32'(mem_we), 0);
        chk("t1_busy", 32'(busy), 1);
        cyc();
        chk("t1_c2_mem_en", 32'(mem_en), 0);
        chk("t1_c2_rvalid", 32'(if_rvalid), 0);
        cyc();
        chk("t1_if_rvalid", 32'(if_rvalid), 1);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);
        chk("t1_d_rvalid", 32'(d_rvalid), 0);
        cyc();
        chk("t1_c4_rvalid", 32'(if_rvalid), 0);
        chk("t1_c4_busy", 32'(busy), 0);

        // 2: simultaneous requests, data first
        if_req = 1; if_addr = 8'h04; d_req = 1; d_we = 0; d_addr = 8'h0C; #1;
        chk("t2_d_gnt", 32'(d_gnt), 1);
        chk("t2_if_gnt", 32'(if_gnt), 0);
        cyc(); d_req = 0;
        cyc(); cyc();
        chk("t2_d_rvalid", 32'(d_rvalid), 1);
        chk("t2_d_rdata", d_rdata, 32'h1111_2222);
        chk("t2_if_rvalid", 32'(if_rvalid), 0);
        chk("t2_resp_if_gnt", 32'(if_gnt), 0);
        cyc();
        chk("t2_if_gnt", 32'(if_gnt), 1);
        chk("t2_idle_d_gnt", 32'(d_gnt), 0);
        cyc(); if_req = 0;
        cyc(); cyc();
        chk("t2_if_rvalid2", 32'(if_rvalid), 1);
        chk("t2_if_rdata", if_rdata, 32'hAAAA_5555);
        chk("t2_d_rdata_held", d_rdata, 32'h1111_2222);
        cyc();

        // 3: both held, expect D,D,D,D,F,D with one IDLE cycle between accesses
        d_req = 1; d_addr = 8'h0C; if_req = 1; if_addr = 8'h08; #1;
        for (int g = 0; g < 6; g++) begin
            exp_g = (g == 4) ? 2'b10 : 2'b01;
            if (g > 0) begin
                cyc();
                waited = 1;
                while (!(if_gnt || d_gnt) && waited < 12) begin
                    cyc();
                    waited++;
                end
                chk($sformatf("t3_gap%0d", g), 32'(waited), 4);
            end
            chk($sformatf("t3_grant%0d", g), 32'({if_gnt, d_gnt}), 32'(exp_g));
        end
        cyc(); d_req = 0; if_req = 0;
        cyc(); cyc();
        chk("t3_d_rvalid", 32'(d_rvalid), 1);
        cyc();

        // 4: write then read back, low address bits ignored
        d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF; #1;
        chk("t4_w_gnt", 32'(d_gnt), 1);
        cyc(); d_req = 0; d_we = 0; #1;
        chk("t4_mem_en", 32'(mem_en), 1);
        chk("t4_mem_we", 32'(mem_we), 1);
        chk("t4_mem_addr", 32'(mem_addr), 4);
        chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); cyc();
        chk("t4_w_rvalid", 32'(d_rvalid), 1);
        chk("t4_w_rdata", d_rdata, 0);
        cyc();
        d_req = 1; d_addr = 8'h13; #1;
        chk("t4_r_gnt", 32'(d_gnt), 1);
        cyc(); d_req = 0; #1;
        chk("t4_r_mem_we", 32'(mem_we), 0);
        chk("t4_r_mem_addr", 32'(mem_addr), 4);
        cyc(); cyc();
        chk("t4_r_rvalid", 32'(d_rvalid), 1);
        chk("t4_r_rdata", d_rdata, 32'hDEAD_BEEF);
        cyc();

        // 5: asynchronous reset during WAIT
        if_req = 1; if_addr = 8'h08; #1;
        chk("t5_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0;
        cyc();
        chk("t5_in_wait", 32'(busy), 1);
        rst = 1'b0; #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_mem_en", 32'(mem_en), 0);
        chk("t5_rst_mem_addr", 32'(mem_addr), 0);
        chk("t5_rst_if_rdata", if_rdata, 0);
        chk("t5_rst_d_rdata", d_rdata, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t5_no_rvalid%0d", k), 32'({if_rvalid, d_rvalid}), 0);
        end
        rst = 1'b1;
        cyc();
        if_req = 1; if_addr = 8'h00; #1;
        chk("t5_post_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0;
        cyc();
        chk("t5_post_c2", 32'(if_rvalid), 0);
        cyc();
        chk("t5_post_rvalid", 32'(if_rvalid), 1);
        chk("t5_post_rdata", if_rdata, 32'h1234_5678);

        // 6: MEM_LAT=3 instance, gnt->rvalid = 5, single mem_en
        cyc();
        t_d_req = 1; t_d_addr = 8'h04; #1;
        chk("t6_gnt", 32'(t_d_gnt), 1);
        en_cnt = 0; rv_at = -1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 1) t_d_req = 0;
            en_cnt += int'(t_mem_en);
            if (t_d_rvalid && rv_at < 0) rv_at = k;
        end
        chk("t6_en_cnt", 32'(en_cnt), 1);
        chk("t6_latency", 32'(rv_at), 5);
        chk("t6_rdata", t_d_rdata, 32'hAAAA_5555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
